load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port. Accepts one load or store request at a time from the execute stage and drives the word-wide `memory` block's `address`, `write_data` and `write_enable` inputs. Captures `mem_read_data` for loads and for the read half of sub-word read-modify-write stores. Returns lane-extracted, sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- `MEM_RD_LAT`, default 1: cycles from address presented to `mem_read_data` valid (legal range 1–4).
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit idle; a request is accepted on an edge where `req_valid && req_ready`.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` input 1: loads only; sign-extend sub-word data.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_err` output 1: valid with `resp_valid`; set on misaligned access or reserved size.
- `resp_rdata` output 32: load result, valid with `resp_valid`; 0 for stores and errors.
- `address` output 32: word index to memory, `{2'b0, req_addr[ADDR_W-1:2]}`.
- `write_data` output 32: word written to memory.
- `write_enable` output 1: memory write strobe.
- `mem_read_data` input 32: memory read word.

## Operation
- Request fields are latched on the accept edge. Inputs are ignored while `req_ready=0`.
- Little-endian lanes:
  - Byte lane = `addr[1:0]`.
  - Half lane = `addr[1]`.
- Error conditions:
  - Half access with `addr[0]=1`.
  - Word access with `addr[1:0]!=0`.
  - `req_size=11`.
  - On error: no memory access, go straight to DONE with `resp_err=1`.
- FSM:
  - IDLE: `req_ready=1`.
    - Accept a load or a sub-word store → READ.
    - Accept a word store → WRITE.
    - Accept an error request → DONE.
  - READ: drive `address`, `write_enable=0`, count MEM_RD_LAT cycles. On the last cycle's edge, capture `mem_read_data` into the data register.
    - Load → DONE.
    - Sub-word store → WRITE.
  - WRITE: `write_enable=1` for exactly one cycle.
    - Word store: `write_data = req_wdata`.
    - Sub-word store: `write_data` = captured word with the addressed lane replaced by `req_wdata[7:0]` or `req_wdata[15:0]`.
    - Next state → DONE.
  - DONE: `resp_valid=1` for one cycle → IDLE.
- Load data: extract the addressed lane. If `req_signed`, sign-extend from bit 7 or 15; otherwise zero-extend. Word loads pass through unchanged.
- No backpressure on the response. The consumer must accept `resp_valid` in the cycle it is high.

## Timing
- All outputs are registered.
- Reset values: `req_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `address=0`, `write_data=0`, `write_enable=0`, state IDLE.
- Latency, counted from the accept edge to the cycle in which `resp_valid` is high:
  - Load: MEM_RD_LAT+1.
  - Word store: 2.
  - Sub-word store: MEM_RD_LAT+2.
  - Error: 1.
- The memory samples the write on the edge that ends the WRITE cycle. `address` and `write_data` are stable for the whole WRITE cycle.
- `req_ready` falls the cycle after accept and rises in the cycle after DONE. Maximum throughput is one request per (latency+1) cycles.
- `rst_n` low at any time:
  - Immediately forces `write_enable=0`, `resp_valid=0`, state IDLE.
  - An in-flight read-modify-write is abandoned. No partial write ever occurs, because the write is a single cycle.
- `address` holds its last value in IDLE. `write_enable` is never high outside WRITE.

## Structure
- Package `lsu_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State enum `IDLE`, `READ`, `WRITE`, `DONE`.
  - Lane-select helper constants.
- One combinational sub-module, `lsu_lane_align`. It performs lane extraction with sign/zero extension and store-data merge. The top level holds the FSM, the latency counter and the registers.

## Test plan
- Word store then load, MEM_RD_LAT=1:
  - Store `0x12345678` at `0x198`: `write_enable` high for one cycle with `address=0x66`.
  - Load word at `0x198`: `resp_rdata=0x12345678` in cycle 2 after accept.
- Sub-word loads from word `0x80FF7F01` at byte address `0x1DC`:
  - Signed byte at `+3` → `0xFFFFFF80`.
  - Unsigned byte at `+1` → `0x0000007F`.
  - Signed half at `+2` → `0xFFFF80FF`.
- Byte store of `0xAB` to `0x1DD` over `0x80FF7F01`:
  - Exactly one write with `write_data=0x80FFAB01`.
  - `resp_valid` at cycle 3 (MEM_RD_LAT=1).
- Misaligned word load at `0x1DE` and `req_size=11`:
  - `resp_err=1` and `resp_valid` at cycle 1 after accept.
  - `write_enable` never asserted; `address` unchanged.
- Reset mid-operation: assert `rst_n=0` during READ of a byte store.
  - Outputs return to reset values asynchronously.
  - No write occurs; target word is unchanged.
  - `req_ready=1` after `rst_n` releases.
- Back-to-back: `req_valid` held high with 3 queued loads, MEM_RD_LAT=2.
  - Each request is accepted only when `req_ready=1`.
  - Responses arrive in order, each 3 cycles after its accept.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane
// helpers and the alignment check used at request accept.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  // Half lane is addr[1]: LO selects bits [15:0], HI selects bits [31:16].
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = lane[0];
      SZ_WORD: access_err = |lane;
      default: access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = (lane_i[1] == HALF_LO) ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    load_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_o = {{(32-BYTE_W){signed_i & byte_sel[BYTE_W-1]}}, byte_sel};
      SZ_HALF: load_o = {{(32-HALF_W){signed_i & half_sel[HALF_W-1]}}, half_sel};
      default: load_o = rdata_i;
    endcase
  end

  always_comb begin
    merge_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane_i[1] == HALF_HI) merge_o[31:16] = wdata_i[15:0];
        else                      merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, sub-word stores done as
// read-modify-write. All outputs come straight from registers.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [31:0]       address,
  output logic [31:0]       write_data,
  output logic              write_enable,
  input  logic [31:0]       mem_read_data,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE. The response is a single-cycle resp_valid
  // pulse with no backpressure.

  localparam logic [2:0] LAST_CNT = 3'(MEM_RD_LAT - 1);

  lsu_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        write_enable_q, write_enable_d;

  logic [31:0] load_word;
  logic [31:0] merge_word;

  lsu_lane_align u_lane_align (
    .rdata_i  (mem_read_data),
    .size_i   (size_q),
    .lane_i   (lane_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_word),
    .merge_o  (merge_word)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    address_d    = address_q;
    write_data_d = write_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d      = req_write;
          size_d       = req_size;
          signed_d     = req_signed;
          lane_d       = req_addr[1:0];
          wdata_d      = req_wdata;
          resp_rdata_d = '0;
          // Errored requests leave the memory port untouched, address included.
          if (access_err(req_size, req_addr[1:0])) begin
            state_d    = DONE;
            resp_err_d = 1'b1;
          end else begin
            address_d = 32'(req_addr[ADDR_W-1:2]);
            if (req_write && req_size == SZ_WORD) begin
              state_d      = WRITE;
              write_data_d = req_wdata;
            end else begin
              state_d = READ;
              cnt_d   = '0;
            end
          end
        end
      end
      READ: begin
        if (cnt_q == LAST_CNT) begin
          if (write_q) begin
            state_d      = WRITE;
            write_data_d = merge_word;
          end else begin
            state_d      = DONE;
            resp_rdata_d = load_word;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    req_ready_d    = (state_d == IDLE);
    resp_valid_d   = (state_d == DONE);
    write_enable_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      write_q        <= 1'b0;
      size_q         <= SZ_BYTE;
      signed_q       <= 1'b0;
      lane_q         <= '0;
      wdata_q        <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      address_q      <= '0;
      write_data_q   <= '0;
      write_enable_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      write_q        <= write_d;
      size_q         <= size_d;
      signed_q       <= signed_d;
      lane_q         <= lane_d;
      wdata_q        <= wdata_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_rdata_q   <= resp_rdata_d;
      address_q      <= address_d;
      write_data_q   <= write_data_d;
      write_enable_q <= write_enable_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign address      = address_q;
  assign write_data   = write_data_q;
  assign write_enable = write_enable_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 2) each on a
// small word memory model, driven from a vector table plus hand sequences.
module tb_load_store_unit;

  localparam int EXP_W = 49;  // {due_cycle[15:0], err, rdata[31:0]}

  typedef struct {
    int          d;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          nwr;
    logic [31:0] wdat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        resp_valid   [2];
  logic        resp_err     [2];
  logic        write_enable [2];
  logic [31:0] resp_rdata   [2];
  logic [31:0] address      [2];
  logic [31:0] write_data   [2];
  logic [31:0] mem_rdata    [2];
  logic [1:0]  dbg_state    [2];
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem [2][256];
  logic [31:0] rd_pipe;
  logic        bd_we;
  int          bd_d;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  logic [EXP_W-1:0] exp_q0[$];
  logic [EXP_W-1:0] exp_q1[$];
  int          n_vec;
  int          n_miss;
  int          cyc;
  int          wr_cnt   [2];
  logic [31:0] wr_addr  [2];
  logic [31:0] wr_data  [2];
  logic [31:0] exp_addr [2];
  vec_t        vecs     [22];

  load_store_unit #(.MEM_RD_LAT(1), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_err(resp_err[0]), .resp_rdata(resp_rdata[0]),
    .address(address[0]), .write_data(write_data[0]), .write_enable(write_enable[0]),
    .mem_read_data(mem_rdata[0]), .dbg_state(dbg_state[0])
  );

  load_store_unit #(.MEM_RD_LAT(2), .ADDR_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_err(resp_err[1]), .resp_rdata(resp_rdata[1]),
    .address(address[1]), .write_data(write_data[1]), .write_enable(write_enable[1]),
    .mem_read_data(mem_rdata[1]), .dbg_state(dbg_state[1])
  );

  // Clock and memory models: latency 1 reads combinationally, latency 2 through one register.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_d][bd_idx] <= bd_data;
    if (write_enable[0]) mem[0][address[0][7:0]] <= write_data[0];
    if (write_enable[1]) mem[1][address[1][7:0]] <= write_data[1];
    rd_pipe <= mem[1][address[1][7:0]];
  end

  assign mem_rdata[0] = mem[0][address[0][7:0]];
  assign mem_rdata[1] = rd_pipe;

  function automatic vec_t mk(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic err,
                              input logic [31:0] rdata, input int nwr, input logic [31:0] wdat);
    vec_t v;
    v.d = d; v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.nwr = nwr; v.wdat = wdat;
    return v;
  endfunction

  function automatic int exp_lat(input int d, input logic wr, input logic [1:0] sz, input logic err);
    int lat;
    lat = (d == 0) ? 1 : 2;
    if (err) return 1;
    if (!wr) return lat + 1;
    if (sz == 2'b10) return 2;
    return lat + 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_resp(input int d);
    logic [EXP_W-1:0] e;
    int qs;
    qs = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (qs == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL resp_unexpected dut%0d: got resp_valid=1, expected no response (cycle %0d)", d, cyc);
    end else begin
      if (d == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      check($sformatf("resp_rdata dut%0d", d), resp_rdata[d], e[31:0]);
      check($sformatf("resp_err dut%0d", d), 32'(resp_err[d]), 32'(e[32]));
      check($sformatf("resp_cycle dut%0d", d), 32'(cyc[15:0]), 32'(e[48:33]));
    end
  endtask

  // One clock: sample outputs on the falling edge, log writes, score responses.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (write_enable[d]) begin
        wr_cnt[d]++;
        wr_addr[d] = address[d];
        wr_data[d] = write_data[d];
      end
      if (resp_valid[d]) check_resp(d);
    end
  endtask

  task automatic backdoor(input int d, input logic [7:0] idx, input logic [31:0] data);
    bd_we = 1'b1; bd_d = d; bd_idx = idx; bd_data = data;
    step();
    bd_we = 1'b0;
  endtask

  // Drive a request and hold it until req_ready; the next rising edge accepts it.
  task automatic issue(input vec_t v);
    int g;
    logic [15:0] due;
    req_write = v.wr; req_size = v.sz; req_signed = v.sg;
    req_addr = v.addr; req_wdata = v.wdata;
    req_valid[v.d] = 1'b1;
    g = 0;
    while (!req_ready[v.d] && g < 40) begin
      step();
      g++;
    end
    check($sformatf("accept_ready dut%0d", v.d), 32'(req_ready[v.d]), 32'd1);
    due = 16'(cyc + exp_lat(v.d, v.wr, v.sz, v.err));
    if (v.d == 0) exp_q0.push_back({due, v.err, v.rdata});
    else          exp_q1.push_back({due, v.err, v.rdata});
    if (!v.err) exp_addr[v.d] = v.addr >> 2;
    step();
  endtask

  task automatic drain(input int d);
    int g;
    g = 0;
    while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 && g < 40) begin
      step();
      g++;
    end
    check($sformatf("drain dut%0d", d), 32'((d == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int w0;
    w0 = wr_cnt[v.d];
    issue(v);
    req_valid[v.d] = 1'b0;
    drain(v.d);
    check($sformatf("v%0d write_count", idx), 32'(wr_cnt[v.d] - w0), 32'(v.nwr));
    if (v.nwr > 0) begin
      check($sformatf("v%0d write_data", idx), wr_data[v.d], v.wdat);
      check($sformatf("v%0d write_addr", idx), wr_addr[v.d], v.addr >> 2);
    end
    check($sformatf("v%0d address_hold", idx), address[v.d], exp_addr[v.d]);
  endtask

  initial begin
    vec_t v;
    int   w0;
    n_vec = 0; n_miss = 0; cyc = 0;
    rst_n = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_d = 0; bd_idx = '0; bd_data = '0;
    for (int d = 0; d < 2; d++) begin
      wr_cnt[d] = 0; wr_addr[d] = '0; wr_data[d] = '0; exp_addr[d] = '0;
    end

    //            d  wr    size   sg    addr          wdata          err   rdata          nwr wdat
    vecs[0]  = mk(0, 1'b1, 2'b10, 1'b0, 32'h0000_0198, 32'h1234_5678, 1'b0, 32'h0000_0000, 1, 32'h1234_5678);
    vecs[1]  = mk(0, 1'b0, 2'b10, 1'b0, 32'h0000_0198, 32'h0000_0000, 1'b0, 32'h1234_5678, 0, 32'h0);
    vecs[2]  = mk(0, 1'b0, 2'b00, 1'b1, 32'h0000_01DF, 32'h0000_0000, 1'b0, 32'hFFFF_FF80, 0, 32'h0);
    vecs[3]  = mk(0, 1'b0, 2'b00, 1'b0, 32'h0000_01DD, 32'h0000_0000, 1'b0, 32'h0000_007F, 0, 32'h0);
    vecs[4]  = mk(0, 1'b0, 2'b01, 1'b1, 32'h0000_01DE, 32'h0000_0000, 1'b0, 32'hFFFF_80FF, 0, 32'h0);
    vecs[5]  = mk(0, 1'b0, 2'b01, 1'b0, 32'h0000_01DE, 32'h0000_0000, 1'b0, 32'h0000_80FF, 0, 32'h0);
    vecs[6]  = mk(0, 1'b0, 2'b00, 1'b1, 32'h0000_01DC, 32'h0000_0000, 1'b0, 32'h0000_0001, 0, 32'h0);
    vecs[7]  = mk(0, 1'b0, 2'b01, 1'b1, 32'h0000_01DC, 32'h0000_0000, 1'b0, 32'h0000_7F01, 0, 32'h0);
    vecs[8]  = mk(0, 1'b0, 2'b10, 1'b0, 32'h0000_01DE, 32'h0000_0000, 1'b1, 32'h0000_0000, 0, 32'h0);
    vecs[9]  = mk(0, 1'b0, 2'b11, 1'b0, 32'h0000_01DC, 32'h0000_0000, 1'b1, 32'h0000_0000, 0, 32'h0);
    vecs[10] = mk(0, 1'b0, 2'b01, 1'b1, 32'h0000_01DD, 32'h0000_0000, 1'b1, 32'h0000_0000, 0, 32'h0);
    vecs[11] = mk(0, 1'b1, 2'b00, 1'b0, 32'h0000_01DD, 32'hFFFF_FFAB, 1'b0, 32'h0000_0000, 1, 32'h80FF_AB01);
    vecs[12] = mk(0, 1'b0, 2'b10, 1'b0, 32'h0000_01DC, 32'h0000_0000, 1'b0, 32'h80FF_AB01, 0, 32'h0);
    vecs[13] = mk(0, 1'b1, 2'b01, 1'b0, 32'h0000_01DE, 32'h1234_BEEF, 1'b0, 32'h0000_0000, 1, 32'hBEEF_AB01);
    vecs[14] = mk(0, 1'b0, 2'b01, 1'b0, 32'h0000_01DE, 32'h0000_0000, 1'b0, 32'h0000_BEEF, 0, 32'h0);
    vecs[15] = mk(0, 1'b1, 2'b10, 1'b0, 32'h0000_019A, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 0, 32'h0);
    vecs[16] = mk(1, 1'b0, 2'b00, 1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0000_0055, 0, 32'h0);
    vecs[17] = mk(1, 1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0000_0000, 1'b0, 32'hFFFF_FF8A, 0, 32'h0);
    vecs[18] = mk(1, 1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0000_0000, 1'b0, 32'hFFFF_CAFE, 0, 32'h0);
    vecs[19] = mk(1, 1'b1, 2'b00, 1'b0, 32'h0000_0043, 32'h0000_0011, 1'b0, 32'h0000_0000, 1, 32'h11FE_8A55);
    vecs[20] = mk(1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h11FE_8A55, 0, 32'h0);
    vecs[21] = mk(1, 1'b1, 2'b11, 1'b0, 32'h0000_0044, 32'h0000_0022, 1'b1, 32'h0000_0000, 0, 32'h0);

    // Reset state, checked while reset is still held.
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst req_ready dut%0d", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("rst resp_valid dut%0d", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("rst resp_err dut%0d", d), 32'(resp_err[d]), 32'd0);
      check($sformatf("rst resp_rdata dut%0d", d), resp_rdata[d], 32'd0);
      check($sformatf("rst address dut%0d", d), address[d], 32'd0);
      check($sformatf("rst write_data dut%0d", d), write_data[d], 32'd0);
      check($sformatf("rst write_enable dut%0d", d), 32'(write_enable[d]), 32'd0);
      check($sformatf("rst state dut%0d", d), 32'(dbg_state[d]), 32'd0);
    end
    rst_n = 1'b1;
    step();

    backdoor(0, 8'h77, 32'h80FF_7F01);
    backdoor(1, 8'h10, 32'hCAFE_8A55);
    for (int i = 0; i < 22; i++) apply_vec(vecs[i], i);

    // Back-to-back loads on the latency-2 unit with req_valid never dropped.
    backdoor(1, 8'h30, 32'hA1B2_C3D4);
    backdoor(1, 8'h31, 32'h0000_0080);
    backdoor(1, 8'h32, 32'h7FFF_8001);
    issue(mk(1, 1'b0, 2'b10, 1'b0, 32'h0000_00C0, 32'h0, 1'b0, 32'hA1B2_C3D4, 0, 32'h0));
    issue(mk(1, 1'b0, 2'b00, 1'b1, 32'h0000_00C4, 32'h0, 1'b0, 32'hFFFF_FF80, 0, 32'h0));
    issue(mk(1, 1'b0, 2'b01, 1'b0, 32'h0000_00CA, 32'h0, 1'b0, 32'h0000_7FFF, 0, 32'h0));
    req_valid[1] = 1'b0;
    drain(1);

    // Reset in the READ cycle of a byte store: no write, outputs clear at once.
    backdoor(0, 8'h20, 32'h1122_3344);
    w0 = wr_cnt[0];
    v = mk(0, 1'b1, 2'b00, 1'b0, 32'h0000_0081, 32'h0000_0099, 1'b0, 32'h0, 1, 32'h1122_9944);
    issue(v);
    check("mid state is READ", 32'(dbg_state[0]), 32'd1);
    rst_n = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    check("async write_enable", 32'(write_enable[0]), 32'd0);
    check("async resp_valid", 32'(resp_valid[0]), 32'd0);
    check("async req_ready", 32'(req_ready[0]), 32'd1);
    check("async state", 32'(dbg_state[0]), 32'd0);
    check("async address", address[0], 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    exp_addr[0] = '0;
    exp_addr[1] = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rst no write", 32'(wr_cnt[0] - w0), 32'd0);
    check("rst target word", mem[0][8'h20], 32'h1122_3344);
    check("rst req_ready after", 32'(req_ready[0]), 32'd1);
    apply_vec(mk(0, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 32'h1122_3344, 0, 32'h0), 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
